hs32_regctl: RTL and testbench



---
 rtl/hs32_regctl.sv | 104 ++++++++++
 tb/tb_hs32_regctl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hs32_regctl.sv
// Client-side controller for the HS32 dual-port register file: arbitrates the
// shared file port between operand reads and writebacks, and buffers read results.
module hs32_regctl #(
    parameter int unsigned MAX_WR_STREAK = 2,
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned DATA_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_a1,
    input  logic [ADDR_W-1:0] rd_a2,
    output logic              rs_valid,
    input  logic              rs_ready,
    output logic [DATA_W-1:0] rs_d1,
    output logic [DATA_W-1:0] rs_d2,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [DATA_W-1:0] wb_din,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wadr,
    output logic [DATA_W-1:0] rf_din,
    output logic [ADDR_W-1:0] rf_radr1,
    output logic [ADDR_W-1:0] rf_radr2,
    input  logic [DATA_W-1:0] rf_dout1,
    input  logic [DATA_W-1:0] rf_dout2
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, HOLD} state_t;

    state_t            state, state_nxt;
    logic [2:0]        streak, streak_nxt;
    logic              read_grant;
    logic [ADDR_W-1:0] radr1_q, radr2_q;

    always_comb begin
        read_grant = 1'b0;
        wb_ready   = 1'b0;
        state_nxt  = state;
        streak_nxt = streak;

        // Writes win by default; a waiting read is forced through once the streak limit is reached.
        if (!reset) begin
            read_grant = (state == IDLE) && rd_valid &&
                         (!wb_valid || 32'(streak) >= MAX_WR_STREAK);
            wb_ready   = wb_valid && !read_grant;
        end

        case (state)
            IDLE:    if (read_grant) state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = HOLD;
            HOLD:    if (rs_valid && rs_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (read_grant || (state == IDLE && !rd_valid))
            streak_nxt = '0;
        else if (state == IDLE && rd_valid && wb_ready && streak != 3'd7)
            streak_nxt = streak + 3'd1;
    end

    assign rd_ready = read_grant;
    assign rf_we    = wb_valid && wb_ready;
    assign rf_wadr  = wb_adr;
    assign rf_din   = wb_din;
    // Bypass so the file samples the requested addresses at the grant edge.
    assign rf_radr1 = read_grant ? rd_a1 : radr1_q;
    assign rf_radr2 = read_grant ? rd_a2 : radr2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_valid <= 1'b0;
            rs_d1    <= '0;
            rs_d2    <= '0;
            radr1_q  <= '0;
            radr2_q  <= '0;
        end else begin
            if (read_grant) begin
                radr1_q <= rd_a1;
                radr2_q <= rd_a2;
            end
            if (state == RD_WAIT) begin
                rs_d1    <= rf_dout1;
                rs_d2    <= rf_dout2;
                rs_valid <= 1'b1;
            end else if (state == HOLD && rs_valid && rs_ready) begin
                rs_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hs32_regctl.sv
// Directed bench for hs32_regctl with a behavioural register file that loads
// its read data only on edges where its write enable is low.
module tb_hs32_regctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_valid, rd_ready, rs_valid, rs_ready;
    logic        wb_valid, wb_ready, rf_we;
    logic [3:0]  rd_a1, rd_a2, wb_adr, rf_wadr, rf_radr1, rf_radr2;
    logic [31:0] rs_d1, rs_d2, wb_din, rf_din, rf_dout1, rf_dout2;
    logic [31:0] mem [16];

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    hs32_regctl #(.MAX_WR_STREAK(2), .ADDR_W(4), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_a1(rd_a1), .rd_a2(rd_a2),
        .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_d1(rs_d1), .rs_d2(rs_d2),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_adr(wb_adr), .wb_din(wb_din),
        .rf_we(rf_we), .rf_wadr(rf_wadr), .rf_din(rf_din),
        .rf_radr1(rf_radr1), .rf_radr2(rf_radr2),
        .rf_dout1(rf_dout1), .rf_dout2(rf_dout2)
    );

    always @(posedge clk) begin
        if (rf_we) mem[rf_wadr] <= rf_din;
        else begin
            rf_dout1 <= mem[rf_radr1];
            rf_dout2 <= mem[rf_radr2];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle: inputs change and outputs are sampled mid-low-phase.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rf_dout1 = '0; rf_dout2 = '0;
        reset = 1'b1; rd_valid = 1'b1; wb_valid = 1'b1; rs_ready = 1'b0;
        rd_a1 = 4'd6; rd_a2 = 4'd7; wb_adr = 4'd1; wb_din = 32'h1;

        // Reset state
        @(negedge clk); #1;
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_wb_ready", wb_ready, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rs_valid", rs_valid, 0);
        chk("rst_rs_d1", rs_d1, 0);
        chk("rst_rs_d2", rs_d2, 0);
        chk("rst_radr1", rf_radr1, 0);
        chk("rst_radr2", rf_radr2, 0);
        @(negedge clk);
        reset = 1'b0; rd_valid = 1'b0; wb_valid = 1'b0;

        // Write r3 then read r3/r0
        wb_valid = 1'b1; wb_adr = 4'd3; wb_din = 32'hDEADBEEF; #1;
        chk("t1_wb_ready", wb_ready, 1);
        chk("t1_rf_we", rf_we, 1);
        chk("t1_rf_wadr", rf_wadr, 3);
        chk("t1_rf_din", rf_din, 32'hDEADBEEF);
        step();
        wb_valid = 1'b0; rd_valid = 1'b1; rd_a1 = 4'd3; rd_a2 = 4'd0; #1;
        chk("t1_rd_ready", rd_ready, 1);
        chk("t1_radr1_bypass", rf_radr1, 3);
        chk("t1_radr2_bypass", rf_radr2, 0);
        step();
        rd_valid = 1'b0; rd_a1 = 4'd9; #1;
        chk("t1_rs_valid_t1", rs_valid, 0);
        chk("t1_radr1_held", rf_radr1, 3);
        step();
        rs_ready = 1'b1; #1;
        chk("t1_rs_valid_t2", rs_valid, 1);
        chk("t1_rs_d1", rs_d1, 32'hDEADBEEF);
        chk("t1_rs_d2", rs_d2, 0);
        step();
        rs_ready = 1'b0; #1;
        chk("t1_popped", rs_valid, 0);
        chk("t1_d1_hold", rs_d1, 32'hDEADBEEF);

        // Streak: rd and wb both held high -> W, W, R, then W in RD_WAIT
        rd_valid = 1'b1; rd_a1 = 4'd1; rd_a2 = 4'd3;
        wb_valid = 1'b1; wb_adr = 4'd1; wb_din = 32'h55; #1;
        chk("s_c0_wb", wb_ready, 1);
        chk("s_c0_rd", rd_ready, 0);
        step(); #1;
        chk("s_c1_wb", wb_ready, 1);
        chk("s_c1_rd", rd_ready, 0);
        step(); #1;
        chk("s_c2_rd", rd_ready, 1);
        chk("s_c2_wb", wb_ready, 0);
        chk("s_c2_we", rf_we, 0);
        step();
        wb_din = 32'h66; #1;
        chk("s_c3_wb", wb_ready, 1);
        chk("s_c3_rd", rd_ready, 0);
        step();
        rd_valid = 1'b0; wb_valid = 1'b0; rs_ready = 1'b1; #1;
        chk("s_rs_valid", rs_valid, 1);
        chk("s_rs_d1", rs_d1, 32'h55);
        chk("s_rs_d2", rs_d2, 32'hDEADBEEF);
        step();
        rs_ready = 1'b0;

        // Snapshot: write r5=0x11 at T-1, read at T, write r5=0x22 at T+1
        wb_valid = 1'b1; wb_adr = 4'd5; wb_din = 32'h11;
        step();
        wb_valid = 1'b0; rd_valid = 1'b1; rd_a1 = 4'd5; rd_a2 = 4'd3; #1;
        chk("n_rd_ready", rd_ready, 1);
        step();
        wb_valid = 1'b1; wb_din = 32'h22; #1;
        chk("n_wb_in_rdwait", wb_ready, 1);
        step();
        wb_valid = 1'b0; #1;
        chk("n_rs_valid", rs_valid, 1);
        chk("n_rs_d1", rs_d1, 32'h11);
        // Backpressure: rs_ready low for 5 cycles with rd_valid still high
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            chk("bp_rs_valid", rs_valid, 1);
            chk("bp_rs_d1", rs_d1, 32'h11);
            chk("bp_rs_d2", rs_d2, 32'hDEADBEEF);
            chk("bp_rd_ready", rd_ready, 0);
        end
        rs_ready = 1'b1;
        step();
        rs_ready = 1'b0; #1;
        chk("bp_popped", rs_valid, 0);
        chk("bp_regrant", rd_ready, 1);
        step();

        // Reset asserted in RD_WAIT
        reset = 1'b1; rd_valid = 1'b0; wb_valid = 1'b1; wb_adr = 4'd8; wb_din = 32'h77; #1;
        chk("r_rf_we", rf_we, 0);
        chk("r_wb_ready", wb_ready, 0);
        chk("r_rs_valid", rs_valid, 0);
        step(); #1;
        chk("r_rf_we_hold", rf_we, 0);
        reset = 1'b0; wb_valid = 1'b0;
        step(); #1;
        chk("r_no_response", rs_valid, 0);
        rd_valid = 1'b1; wb_valid = 1'b1; #1;
        chk("r_c0_wb", wb_ready, 1);
        chk("r_c0_rd", rd_ready, 0);
        step(); #1;
        chk("r_c1_wb", wb_ready, 1);
        chk("r_c1_rd", rd_ready, 0);
        step(); #1;
        chk("r_c2_rd", rd_ready, 1);
        step();
        rd_valid = 1'b0; wb_valid = 1'b0;
        step();
        rs_ready = 1'b1; #1;
        chk("r_rs_valid", rs_valid, 1);
        chk("r_rs_d1", rs_d1, 32'h22);
        step();
        rs_ready = 1'b0;

        // Same-cycle write r7 and read r7/r7: write first, read next cycle
        wb_valid = 1'b1; wb_adr = 4'd7; wb_din = 32'hA5A5A5A5;
        rd_valid = 1'b1; rd_a1 = 4'd7; rd_a2 = 4'd7; #1;
        chk("c_wb_first", wb_ready, 1);
        chk("c_rd_wait", rd_ready, 0);
        step();
        wb_valid = 1'b0; #1;
        chk("c_rd_next", rd_ready, 1);
        step();
        rd_valid = 1'b0;
        step();
        rs_ready = 1'b1; #1;
        chk("c_rs_valid", rs_valid, 1);
        chk("c_rs_d1", rs_d1, 32'hA5A5A5A5);
        chk("c_rs_d2", rs_d2, 32'hA5A5A5A5);
        step();
        rs_ready = 1'b0; #1;
        chk("c_popped", rs_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
